// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DIVIDEND_W = 64;
    localparam int DIVISOR_W  = 32;
    localparam int QUOT_W     = 32;
    localparam int ITER       = 64;

    localparam logic [QUOT_W-1:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [QUOT_W-1:0] Q_MIN = 32'h8000_0000;

    // Magnitude as unsigned; the most negative value maps exactly onto 2^(W-1).
    function automatic logic [DIVIDEND_W-1:0] abs_dividend(input logic [DIVIDEND_W-1:0] v);
        return v[DIVIDEND_W-1] ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [DIVISOR_W-1:0] abs_divisor(input logic [DIVISOR_W-1:0] v);
        return v[DIVISOR_W-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/result handshake bundle between a client and div_seq.
interface div_seq_if;
    import div_pkg::*;

    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  in_valid;
    logic                  in_ready;
    logic [QUOT_W-1:0]     quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  overflow;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  dividend, divisor, in_valid, out_ready,
        output in_ready, quotient, remainder, div_by_zero, overflow, out_valid
    );

    modport master (
        output dividend, divisor, in_valid, out_ready,
        input  in_ready, quotient, remainder, div_by_zero, overflow, out_valid
    );

endinterface

// File: rtl/div_seq.sv
// Sequential 64/32 signed divider: restoring shift-subtract on magnitudes,
// sign fix-up and int32 saturation of the quotient, one operation in flight.
module div_seq
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_seq_if.slave   bus
);

    state_t                state_r;
    state_t                state_s;
    logic [5:0]            count_r;
    logic [DIVIDEND_W-1:0] quo_r;
    logic [DIVISOR_W-1:0]  rem_r;
    logic [DIVISOR_W-1:0]  dvs_r;
    logic                  sign_q_r;
    logic                  sign_r_r;

    logic [QUOT_W-1:0]     quotient_r;
    logic [DIVISOR_W-1:0]  remainder_r;
    logic                  dz_r;
    logic                  ov_r;
    logic                  out_valid_r;
    logic                  in_ready_r;

    logic                  accept_s;
    logic                  hs_s;
    logic [DIVISOR_W:0]    rem_shift_s;
    logic [DIVISOR_W-1:0]  diff_s;
    logic                  ge_s;
    logic [QUOT_W-1:0]     fix_q_s;
    logic                  fix_ov_s;
    logic [DIVISOR_W-1:0]  fix_r_s;

    assign accept_s    = (state_r == IDLE) && in_ready_r && bus.in_valid;
    assign hs_s        = (state_r == DONE) && out_valid_r && bus.out_ready;

    // Partial remainder never exceeds the divisor magnitude, so 33 bits suffice.
    assign rem_shift_s = {rem_r, quo_r[DIVIDEND_W-1]};
    assign ge_s        = (rem_shift_s >= {1'b0, dvs_r});
    assign diff_s      = rem_shift_s[DIVISOR_W-1:0] - dvs_r;

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dz_r;
    assign bus.overflow    = ov_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = (bus.divisor == 32'd0) ? DONE : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (count_r == 6'(ITER - 1)) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX:  state_s = DONE;
            DONE: begin
                if (hs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Sign fix-up and saturation of the finished magnitudes.
    always_comb begin
        fix_q_s  = quo_r[QUOT_W-1:0];
        fix_ov_s = 1'b0;
        if (sign_q_r) begin
            if (quo_r > 64'h0000_0000_8000_0000) begin
                fix_q_s  = Q_MIN;
                fix_ov_s = 1'b1;
            end else begin
                fix_q_s  = ~quo_r[QUOT_W-1:0] + 32'd1;
                fix_ov_s = 1'b0;
            end
        end else if (quo_r > 64'h0000_0000_7FFF_FFFF) begin
            fix_q_s  = Q_MAX;
            fix_ov_s = 1'b1;
        end else begin
            fix_q_s  = quo_r[QUOT_W-1:0];
            fix_ov_s = 1'b0;
        end
        fix_r_s = sign_r_r ? (~rem_r + 32'd1) : rem_r;
    end

    // Datapath, iteration counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= 6'd0;
            quo_r       <= 64'd0;
            rem_r       <= 32'd0;
            dvs_r       <= 32'd0;
            sign_q_r    <= 1'b0;
            sign_r_r    <= 1'b0;
            quotient_r  <= 32'd0;
            remainder_r <= 32'd0;
            dz_r        <= 1'b0;
            ov_r        <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sign_q_r   <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
                        sign_r_r   <= bus.dividend[DIVIDEND_W-1];
                        quo_r      <= abs_dividend(bus.dividend);
                        dvs_r      <= abs_divisor(bus.divisor);
                        rem_r      <= 32'd0;
                        count_r    <= 6'd0;
                        in_ready_r <= 1'b0;
                        // Zero divisor: result is known now, out_valid follows next edge.
                        if (bus.divisor == 32'd0) begin
                            quotient_r  <= bus.dividend[DIVIDEND_W-1] ? Q_MIN : Q_MAX;
                            remainder_r <= 32'd0;
                            dz_r        <= 1'b1;
                            ov_r        <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_r   <= ge_s ? diff_s : rem_shift_s[DIVISOR_W-1:0];
                    quo_r   <= {quo_r[DIVIDEND_W-2:0], ge_s};
                    count_r <= count_r + 6'd1;
                end
                FIX: begin
                    quotient_r  <= fix_q_s;
                    remainder_r <= fix_r_s;
                    dz_r        <= 1'b0;
                    ov_r        <= fix_ov_s;
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential signed divider, the inverse of the pipelined 32x32 signed multiplier in the datapath. It takes a 64-bit signed dividend, typically a multiplier product or an accumulated sum, and a 32-bit signed divisor. It returns a 32-bit saturated quotient and a 32-bit remainder over a valid/ready handshake. It serves average pooling and rescaling stages of the LeNet5 pipeline, where divides are rare and a single-cycle divider is not justified.

## Interface
Parameters: none; all widths are fixed (see package).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous to clk, active-high
- dividend  in  64  signed dividend
- divisor  in  32  signed divisor
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- quotient  out  32  signed quotient, truncated toward zero, saturated
- remainder  out  32  signed remainder; sign follows dividend
- div_by_zero  out  1  flag valid with out_valid
- overflow  out  1  flag valid with out_valid; quotient outside int32 range
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 on an edge, capture operands and store sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Load |dividend| into a 64-bit unsigned register and |divisor| into a 32-bit unsigned register. |−2^63| = 2^63 and |−2^31| = 2^31 must be exact.
  - If divisor == 0, go to DONE; otherwise go to CALC with count=0.
- CALC: one restoring shift-subtract iteration per cycle, MSB first, with a 33-bit partial remainder. After 64 iterations (count 0..63), go to FIX.
- FIX:
  - Apply sign_q to the 64-bit quotient magnitude and sign_r to the remainder.
  - If the signed quotient is greater than 2^31−1, output 0x7FFFFFFF with overflow=1. If it is less than −2^31, output 0x80000000 with overflow=1.
  - Remainder is never saturated; it always fits in int32.
  - Go to DONE.
- Divide by zero:
  - quotient = 0x7FFFFFFF if dividend ≥ 0, otherwise 0x80000000.
  - remainder = 0, div_by_zero=1, overflow=0.
- DONE:
  - out_valid=1. quotient, remainder and both flags are held stable until out_ready=1.
  - On an edge with out_valid & out_ready, go to IDLE.
- No overlap: only one operation is in flight at a time. in_valid is ignored outside IDLE.
- Reset:
  - Any state goes to IDLE. An in-flight operation is dropped.
  - All outputs are 0 except in_ready, which is 1 after reset.
  - Reset has priority over every other event.

## Timing
- Let the accept edge be t0 (in_valid & in_ready).
- Normal divide: CALC occupies edges t1..t64, FIX is at t65, and out_valid is high from after t65. Latency is 65 cycles.
- Divide by zero: out_valid is high from after t1. Latency is 1 cycle.
- With out_ready held high, out_valid lasts exactly 1 cycle.
- in_ready rises the cycle after the out_valid & out_ready edge.
- Minimum issue interval is 67 cycles; for divide by zero it is 3 cycles.
- in_ready is registered; there is no combinational path from in_valid to in_ready or from out_ready to out_valid.
- Outputs are registered and change only on the FIX edge, the zero-divisor accept edge, reset, or the handshake edge.

## Structure
- Package div_pkg holds:
  - state enum {IDLE, CALC, FIX, DONE};
  - DIVIDEND_W=64, DIVISOR_W=32, QUOT_W=32, ITER=64;
  - Q_MAX=32'h7FFFFFFF and Q_MIN=32'h80000000.
- There are no sub-modules: one FSM, one iteration counter and one datapath, in a single module.

## Test plan
- 100 / 7 -> quotient=14, remainder=2, flags 0, out_valid exactly 65 cycles after accept.
- −100 / 7 -> quotient=−14, remainder=−2. 100 / −7 -> quotient=−14, remainder=2.
- Saturation cases:
  - 2^40 / 2 -> quotient=0x7FFFFFFF, overflow=1.
  - −2^31 / −1 -> quotient=0x7FFFFFFF, overflow=1.
  - −2^63 / 1 -> quotient=0x80000000, overflow=1.
- Divide by zero:
  - 5 / 0 -> quotient=0x7FFFFFFF, remainder=0, div_by_zero=1, out_valid 1 cycle after accept.
  - −5 / 0 -> quotient=0x80000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout. Assert in_valid with new operands during the stall -> ignored. Release out_ready -> in_ready=1 the next cycle.
- Reset at CALC count 30 -> next cycle in IDLE, out_valid=0, in_ready=1. A following 9 / 3 -> quotient=3, remainder=0.
